maxpool2x2_stream: RTL and testbench
====================================

Name: maxpool2x2_stream

Overview:
- Streaming 2x2, stride-2 max-pooling stage placed directly downstream of the convolution unit's result output.
- Consumes conv results in raster order, one pixel per beat, all FILTER_NUM channels in parallel.
- Emits the pooled feature map (IMG_W/2 x IMG_H/2 x FILTER_NUM) in raster order.
- Replaces full-frame buffering before pooling with a single half-width line buffer.

Parameters:
- IMG_W, 256, input columns per row; must be even.
- IMG_H, 256, input rows per frame; must be even.
- FILTER_NUM, 16, channels (lanes) per beat.
- DATA_WIDTH, 16, lane width, two's-complement signed.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  in_data carries a valid pixel.
- in_ready  out  1  block accepts the pixel this cycle.
- in_data  in  FILTER_NUM*DATA_WIDTH  lane j at [j*DATA_WIDTH +: DATA_WIDTH].
- out_valid  out  1  out_data holds a pooled pixel.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  FILTER_NUM*DATA_WIDTH  pooled pixel, same lane packing as in_data.
- out_last  out  1  qualifies out_data as the final pooled pixel of the frame.
- frame_done  out  1  one-cycle pulse when the out_last beat is accepted.

Behaviour:
- Reset values (asynchronous):
  - col/row counters = 0.
  - out_valid, out_last, frame_done, out_data = 0.
  - Horizontal hold register = 0.
  - Line buffer (IMG_W/2 entries x FILTER_NUM*DATA_WIDTH) is not reset; every entry is written before it is read.
- Handshake and stall rules:
  - Accept = in_valid & in_ready.
  - in_ready = ~out_valid | out_ready (combinational).
  - out_data and out_last are held stable while out_valid & ~out_ready.
  - Counters advance only on accept.
- Counters: col counts 0..IMG_W-1. At col = IMG_W-1, col wraps to 0 and row increments. At row = IMG_H-1 and col = IMG_W-1, both wrap to 0 and the next accepted beat starts a new frame. Frames may be back-to-back with no gap.
- Per accepted beat, all operations are per lane, using signed compare:
  - Even col: hold <= in_data.
  - Odd col, even row: line_buf[col>>1] <= max(hold, in_data).
  - Odd col, odd row: out_data <= max(line_buf[col>>1], max(hold, in_data)). out_valid <= 1. out_last <= (row = IMG_H-1 && col = IMG_W-1).
- Output register:
  - out_valid clears on out_ready when no new result is loaded in that cycle.
  - A simultaneous drain and load keeps out_valid = 1 and loads the new data.
- Latency: out_valid rises the cycle after the odd-row/odd-col beat is accepted.
- Throughput: one input beat per cycle when out_ready is held high.
- Ties (equal values): either operand may be selected, since the result is identical.
- frame_done = out_valid & out_ready & out_last, registered into a single-cycle pulse on the following cycle.
- Reset mid-frame: the partial frame is discarded and any pending output is dropped. The first accepted beat after reset is treated as row 0, col 0.
- Width rules: no arithmetic growth; outputs keep DATA_WIDTH; compare is full-width signed.

Test Plan (IMG_W=4, IMG_H=4, FILTER_NUM=2 unless stated):
- Ramp, out_ready=1: lane0 = r*4+c, lane1 = -(r*4+c), 16 back-to-back beats -> lane0 outputs 5,7,13,15; lane1 outputs 0,-2,-8,-10; out_last only on the 4th output; frame_done pulses once.
- Signed extremes: one 2x2 block {-32768, 32767, -1, 0} -> 32767; a block of all -32768 -> -32768 (0x8000).
- Backpressure: out_ready=0 from the first output onward -> out_data stays 5; in_ready=0 from the next cycle until out_ready returns to 1; no beat is lost (outputs still 5,7,13,15).
- Simultaneous drain/load: out_ready=1 every cycle with a new result -> out_valid stays high and each output appears exactly once.
- Reset mid-frame: assert reset after 6 beats, then stream a fresh ramp -> outputs 5,7,13,15 with no residue from the aborted frame.
- Two consecutive frames with in_valid gaps at random beats -> 8 outputs total, out_last on the 4th and 8th, two frame_done pulses.

Source files
------------

// File: rtl/maxpool2x2_stream.sv
// maxpool2x2_stream: streaming 2x2 stride-2 max-pool over raster-order conv results
module maxpool2x2_stream #(
    parameter int IMG_W      = 256,
    parameter int IMG_H      = 256,
    parameter int FILTER_NUM = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [FILTER_NUM*DATA_WIDTH-1:0] in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [FILTER_NUM*DATA_WIDTH-1:0] out_data,
    output logic                             out_last,
    output logic                             frame_done
);
    localparam int W  = FILTER_NUM * DATA_WIDTH;
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [W-1:0]  hold;
    logic [W-1:0]  hmax;
    logic [W-1:0]  pmax;
    logic [W-1:0]  lb_rd;
    logic [W-1:0]  line_buf [IMG_W/2];
    logic          acc;
    logic          col_end;
    logic          row_end;
    logic          load;

    assign in_ready = ~out_valid | out_ready;
    assign acc      = in_valid & in_ready;
    assign col_end  = col == COL_MAX;
    assign row_end  = row == ROW_MAX;
    assign load     = acc & col[0] & row[0];
    assign lb_rd    = line_buf[col[CW-1:1]];

    for (genvar j = 0; j < FILTER_NUM; j++) begin : g_lane
        logic signed [DATA_WIDTH-1:0] h, x, b, m;
        assign h = hold[j*DATA_WIDTH +: DATA_WIDTH];
        assign x = in_data[j*DATA_WIDTH +: DATA_WIDTH];
        assign b = lb_rd[j*DATA_WIDTH +: DATA_WIDTH];
        assign m = (x > h) ? x : h;
        assign hmax[j*DATA_WIDTH +: DATA_WIDTH] = m;
        assign pmax[j*DATA_WIDTH +: DATA_WIDTH] = (b > m) ? b : m;
    end

    // raster position counters and the even-column hold register advance on accept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col  <= '0;
            row  <= '0;
            hold <= '0;
        end else if (acc) begin
            col <= col_end ? '0 : col + 1'b1;
            if (col_end)
                row <= row_end ? '0 : row + 1'b1;
            if (!col[0])
                hold <= in_data;
        end
    end

    // even rows park the horizontal pair max for the odd row below; entries are always written before read
    always_ff @(posedge clk) begin
        if (acc && col[0] && !row[0])
            line_buf[col[CW-1:1]] <= hmax;
    end

    // output register: loads on odd/odd beats, drains on out_ready, pulses frame_done after last handoff
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= out_valid & out_ready & out_last;
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= pmax;
                out_last  <= row_end & col_end;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_maxpool2x2_stream.sv
// tb_maxpool2x2_stream: directed checks of the 2x2 max-pool stream on a 4x4x2 frame
module tb_maxpool2x2_stream;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        out_last;
    logic        frame_done;

    int          n_tests = 0;
    int          n_fail = 0;
    int          fd_cnt = 0;
    int          valid_cycles = 0;
    logic [31:0] got_q [$];
    logic        glast_q [$];
    logic [31:0] frame_px [16];
    logic [31:0] exp_px [4];

    maxpool2x2_stream #(
        .IMG_W(4),
        .IMG_H(4),
        .FILTER_NUM(2),
        .DATA_WIDTH(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_last(out_last),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // record every output handoff and frame_done pulse, sampled mid-cycle
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                glast_q.push_back(out_last);
            end
            if (out_valid)
                valid_cycles++;
            if (frame_done)
                fd_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_accept();
        bit ok = 1'b0;
        int k = 0;
        while (!ok && k < 200) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            k++;
        end
        if (!ok)
            check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_beats(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = frame_px[i];
            wait_accept();
        end
        in_valid = 1'b0;
    endtask

    task automatic clear_obs();
        got_q.delete();
        glast_q.delete();
        fd_cnt = 0;
        valid_cycles = 0;
    endtask

    task automatic check_outputs(input string tag, input int nframes);
        int k = 0;
        while (got_q.size() < 4 * nframes && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_count"}, got_q.size(), 4 * nframes);
        for (int i = 0; i < 4 * nframes; i++) begin
            if (i < got_q.size()) begin
                check($sformatf("%s_data%0d", tag, i), got_q[i], exp_px[i % 4]);
                check($sformatf("%s_last%0d", tag, i), {31'd0, glast_q[i]}, {31'd0, i % 4 == 3});
            end
        end
        check({tag, "_frame_done"}, fd_cnt, nframes);
    endtask

    task automatic load_ramp();
        for (int i = 0; i < 16; i++)
            frame_px[i] = {16'(-i), 16'(i)};
        exp_px = '{32'h0000_0005, 32'hFFFE_0007, 32'hFFF8_000D, 32'hFFF6_000F};
    endtask

    initial begin
        logic [15:0] l0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        reset = 1'b0;
        @(posedge clk);
        #1;

        load_ramp();
        clear_obs();
        send_beats(16, 1'b0);
        check_outputs("ramp", 1);
        check("ramp_valid_once", valid_cycles, 4);

        for (int i = 0; i < 16; i++) begin
            case (i)
                0, 2, 3, 6, 7: l0 = 16'h8000;
                1:             l0 = 16'h7FFF;
                4:             l0 = 16'hFFFF;
                default:       l0 = 16'h0000;
            endcase
            frame_px[i] = {~l0, l0};
        end
        exp_px = '{32'h7FFF_7FFF, 32'h7FFF_8000, 32'hFFFF_0000, 32'hFFFF_0000};
        clear_obs();
        send_beats(16, 1'b0);
        check_outputs("extreme", 1);

        load_ramp();
        clear_obs();
        out_ready = 1'b0;
        fork
            send_beats(16, 1'b0);
            begin
                int k = 0;
                while (!out_valid && k < 200) begin
                    @(negedge clk);
                    k++;
                end
                check("bp_seen_valid", {31'd0, out_valid}, 32'd1);
                repeat (3) begin
                    @(negedge clk);
                    check("bp_hold_data", out_data, 32'h0000_0005);
                    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        check_outputs("bp", 1);

        load_ramp();
        clear_obs();
        out_ready = 1'b0;
        send_beats(6, 1'b0);
        check("mid_pending", {31'd0, out_valid}, 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_data", out_data, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        clear_obs();
        send_beats(16, 1'b0);
        check_outputs("midrst", 1);

        load_ramp();
        clear_obs();
        send_beats(16, 1'b1);
        send_beats(16, 1'b1);
        check_outputs("twoframe", 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
